// File: rtl/melody_pkg.sv
// melody_pkg: note codes, ROM word layout and FSM encoding for melody_scheduler
package melody_pkg;
    localparam logic [3:0] REST = 4'd0, C = 4'd1, CS = 4'd2, D = 4'd3, DS = 4'd4, E = 4'd5, F = 4'd6;
    localparam logic [3:0] FS = 4'd7, G = 4'd8, GS = 4'd9, A = 4'd10, AS = 4'd11, B = 4'd12;
    localparam logic [3:0] DEF_OCTAVE = 4'd4;
    localparam int NOTE_W = 4;
    localparam int OCT_W = 4;
    localparam int DUR_LSB = 0;
    function automatic int oct_lsb(input int dur_w);
        return dur_w;
    endfunction
    function automatic int note_lsb(input int dur_w);
        return dur_w + OCT_W;
    endfunction
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, GAP} state_e;
endpackage

// File: rtl/melody_scheduler_note_timer.sv
// note_timer: loadable tick-gated down-counter with freeze and expiry pulse
//   clr_i clears, load_i loads val_i, tick_i decrements unless freeze_i,
//   expire_o flags the tick that takes the count from 1 to 0
module note_timer #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    input  logic         tick_i,
    input  logic         freeze_i,
    output logic         expire_o
);
    logic [W-1:0] cnt_q, cnt_d;
    logic step;
    always_comb begin
        step = tick_i && !freeze_i && cnt_q != '0;
        expire_o = step && cnt_q == W'(1);
        cnt_d = clr_i ? '0 : load_i ? val_i : step ? cnt_q - W'(1) : cnt_q;
    end
    always_ff @(posedge clk) begin
        cnt_q <= rst ? '0 : cnt_d;
    end
endmodule

// File: rtl/melody_scheduler.sv
// melody_scheduler: arbitrates the tone channel between keypad notes and a ROM song player
//   inputs : tick (beat), play/stop pulses, kp_note/kp_octave, rom_data (1-cycle ROM)
//   outputs: rom_addr, note/octave to tone generator, src (keypad), busy, done pulse
module melody_scheduler
    import melody_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DUR_W = 6,
    parameter int GAP_TICKS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              play,
    input  logic              stop,
    input  logic [3:0]        kp_note,
    input  logic [3:0]        kp_octave,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7+DUR_W:0]  rom_data,
    output logic [3:0]        note,
    output logic [3:0]        octave,
    output logic              src,
    output logic              busy,
    output logic              done
);
    localparam int OL = oct_lsb(DUR_W);
    localparam int NL = note_lsb(DUR_W);
    state_e state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0] snote_q, snote_d, soct_q, soct_d, note_q, note_d, oct_q, oct_d;
    logic src_q, busy_q, done_q;
    logic ovr, adv, fin, dur_load, gap_load, dur_exp, gap_exp;
    logic [DUR_W-1:0] rdur;
    assign rdur = rom_data[DUR_LSB +: DUR_W];
    always_comb begin
        ovr = kp_note != REST;
        state_d = state_q;
        addr_d = addr_q;
        snote_d = snote_q;
        soct_d = soct_q;
        adv = 1'b0;
        fin = 1'b0;
        dur_load = 1'b0;
        gap_load = 1'b0;
        if (stop) begin
            state_d = IDLE;
            addr_d = '0;
        end else if (!ovr) begin
            case (state_q)
                IDLE: if (play) begin
                    state_d = FETCH;
                    addr_d = '0;
                end
                FETCH: state_d = LOAD;
                LOAD: begin
                    snote_d = rom_data[NL +: NOTE_W];
                    soct_d = rom_data[OL +: OCT_W];
                    if (rdur == '0) fin = 1'b1;
                    else begin
                        dur_load = 1'b1;
                        state_d = PLAY;
                    end
                end
                PLAY: if (dur_exp) begin
                    if (GAP_TICKS > 0) begin
                        gap_load = 1'b1;
                        state_d = GAP;
                    end else adv = 1'b1;
                end
                GAP: adv = gap_exp;
                default: state_d = IDLE;
            endcase
            // the last ROM slot doubles as an end marker so the address never wraps
            if (adv) begin
                if (&addr_q) fin = 1'b1;
                else begin
                    addr_d = addr_q + ADDR_W'(1);
                    state_d = FETCH;
                end
            end
            if (fin) begin
                state_d = IDLE;
                addr_d = '0;
            end
        end
        note_d = ovr ? kp_note : state_d == PLAY ? snote_d : REST;
        oct_d = (ovr || state_d == IDLE) ? kp_octave : (state_d == PLAY || state_d == GAP) ? soct_d : oct_q;
    end
    note_timer #(.W(DUR_W)) u_dur (
        .clk(clk), .rst(rst), .clr_i(stop), .load_i(dur_load), .val_i(rdur),
        .tick_i(tick && state_q == PLAY), .freeze_i(ovr), .expire_o(dur_exp)
    );
    note_timer #(.W(DUR_W)) u_gap (
        .clk(clk), .rst(rst), .clr_i(stop), .load_i(gap_load), .val_i(DUR_W'(GAP_TICKS)),
        .tick_i(tick && state_q == GAP), .freeze_i(ovr), .expire_o(gap_exp)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q <= '0;
            snote_q <= REST;
            soct_q <= '0;
            note_q <= REST;
            oct_q <= DEF_OCTAVE;
            src_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q <= addr_d;
            snote_q <= snote_d;
            soct_q <= soct_d;
            note_q <= note_d;
            oct_q <= oct_d;
            src_q <= ovr;
            busy_q <= state_d != IDLE;
            done_q <= fin;
        end
    end
    assign rom_addr = addr_q;
    assign note = note_q;
    assign octave = oct_q;
    assign src = src_q;
    assign busy = busy_q;
    assign done = done_q;
endmodule
